imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch front end: ROM address, 2-entry in-order buffer to decode; fetch-to-out_valid 2 cycles.
// Backpressure: out_ready low holds the head entry; fetches stop once buffered plus in-flight reaches 2.
module imem_fetch_ctrl #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clock,
    input  logic        resetn,
    output logic [11:0] imem_addr,
    input  logic [31:0] imem_q,
    input  logic        redirect_valid,
    input  logic [11:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [11:0] out_pc,
    output logic        halted
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [11:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [11:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];
    logic [11:0] buf_pc_q [2];
    logic [11:0] buf_pc_d [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  credit_used;

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_instr = buf_instr_q[rd_ptr_q];
    assign out_pc    = buf_pc_q[rd_ptr_q];
    assign halted    = (state_q == ST_HALT);

    assign pop  = out_valid & out_ready;
    assign push = inflight_q & ~redirect_valid;

    // Counting this cycle's pop lets the buffer stream one word per cycle without gaps.
    assign credit_used = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
    assign issue = (state_q == ST_RUN) & ~redirect_valid & ~halt & (credit_used < 3'd2);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;

        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  if (halt) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            fetch_pc_d    = fetch_pc_q + 12'd1;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end

        if (push) begin
            buf_instr_d[wr_ptr_q] = imem_q;
            buf_pc_d[wr_ptr_q]    = inflight_pc_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        // Redirect wins over everything: drop buffered and returning words, restart at the target.
        if (redirect_valid) begin
            state_d    = ST_RUN;
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 12'h000;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            buf_instr_q   <= '{32'h0, 32'h0};
            buf_pc_q      <= '{12'h000, 12'h000};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios then random ready/redirect/halt traffic against a sequential-stream scoreboard.
module tb_imem_fetch_ctrl;

    localparam logic [11:0] RST_PC = 12'h000;
    localparam int          WIN    = 128;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] imem_addr;
    logic [31:0] imem_q = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = 12'h000;
    logic        halt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [11:0] out_pc;
    logic        halted;

    imem_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    always #5 clock = ~clock;

    // ROM: word[n] = n, registered address.
    always @(posedge clock) imem_q <= {20'h0, imem_addr};

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_deliv = 0;
    logic [11:0] exp_q [$];
    logic [11:0] last_pc = 12'h000;
    logic [11:0] mon_e;
    bit          hold_prev = 1'b0;
    logic [11:0] hold_pc;
    logic [31:0] hold_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Program order after a (re)start is simply start, start+1, ... modulo 4096.
    task automatic load_stream(input logic [11:0] start);
        exp_q.delete();
        for (int i = 0; i < WIN; i++) exp_q.push_back(12'(start + 12'(i)));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_redirect(input logic [11:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        load_stream(pc);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 12 && !out_valid; i++) tick();
        chk(name, {31'h0, out_valid}, 32'd1);
    endtask

    // Monitor: every handshake pops the scoreboard; a stalled head must stay put.
    always @(negedge clock) begin
        if (!resetn) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", {31'h0, out_valid}, 32'd1);
                chk("hold_pc", {20'h0, out_pc}, {20'h0, hold_pc});
                chk("hold_instr", out_instr, hold_instr);
            end
            hold_prev  = out_valid && !out_ready && !redirect_valid;
            hold_pc    = out_pc;
            hold_instr = out_instr;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got pc %h, expected none", out_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("deliv_pc", {20'h0, out_pc}, {20'h0, mon_e});
                end
                chk("deliv_instr", out_instr, {20'h0, out_pc});
                n_deliv++;
                last_pc = out_pc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic ready);
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        out_ready      = ready;
        tick();
        tick();
        load_stream(RST_PC);
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] saved_instr;
        logic [11:0] addr_h;
        logic [11:0] wrap_seq [4];
        int          d0;
        bit          found;
        int          since_redir;
        int          r;

        // Reset values
        #3;
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_imem_addr", {20'h0, imem_addr}, {20'h0, RST_PC});
        chk("rst_halted", {31'h0, halted}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", {20'h0, out_pc}, 32'h0);

        // Streaming from reset
        do_reset(1'b1);
        tick();
        chk("stream_lat_c1", {31'h0, out_valid}, 32'd0);
        tick();
        chk("stream_lat_c2", {31'h0, out_valid}, 32'd0);
        tick();
        chk("stream_first_valid", {31'h0, out_valid}, 32'd1);
        chk("stream_first_pc", {20'h0, out_pc}, 32'h0);
        chk("stream_first_instr", out_instr, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("stream_valid", {31'h0, out_valid}, 32'd1);
            chk("stream_pc", {20'h0, out_pc}, 32'(i));
        end

        // Backpressure
        do_reset(1'b0);
        repeat (8) tick();
        chk("bp_valid", {31'h0, out_valid}, 32'd1);
        chk("bp_head_pc", {20'h0, out_pc}, 32'h0);
        chk("bp_addr", {20'h0, imem_addr}, 32'h2);
        saved_instr = out_instr;
        repeat (5) begin
            tick();
            chk("bp_addr_hold", {20'h0, imem_addr}, 32'h2);
            chk("bp_instr_hold", out_instr, saved_instr);
        end
        out_ready = 1'b1;
        chk("bp_drain_pc0", {20'h0, out_pc}, 32'h0);
        tick();
        chk("bp_drain_v1", {31'h0, out_valid}, 32'd1);
        chk("bp_drain_pc1", {20'h0, out_pc}, 32'h1);
        tick();
        chk("bp_drain_v2", {31'h0, out_valid}, 32'd1);
        chk("bp_drain_pc2", {20'h0, out_pc}, 32'h2);

        // Redirect while pc 5 is returning from the ROM
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid && out_pc == 12'h004) found = 1'b1;
            else tick();
        end
        chk("redir_found_pc4", {31'h0, found}, 32'd1);
        chk("redir_inflight_addr", {20'h0, imem_addr}, 32'h6);
        do_redirect(12'h100);
        chk("redir_flush", {31'h0, out_valid}, 32'd0);
        chk("redir_addr", {20'h0, imem_addr}, 32'h100);
        wait_valid("redir_timeout");
        chk("redir_first_pc", {20'h0, out_pc}, 32'h100);

        // Wrap
        wrap_seq = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        do_redirect(12'hFFE);
        wait_valid("wrap_timeout");
        for (int i = 0; i < 4; i++) begin
            chk("wrap_valid", {31'h0, out_valid}, 32'd1);
            chk("wrap_pc", {20'h0, out_pc}, {20'h0, wrap_seq[i]});
            tick();
        end

        // Halt with one fetch in flight
        addr_h = imem_addr;
        halt   = 1'b1;
        tick();
        chk("halt_halted", {31'h0, halted}, 32'd1);
        repeat (5) begin
            tick();
            chk("halt_no_issue", {20'h0, imem_addr}, {20'h0, addr_h});
        end
        chk("halt_drained", {31'h0, out_valid}, 32'd0);
        chk("halt_last_pc", {20'h0, last_pc}, {20'h0, 12'(addr_h - 12'd1)});
        halt = 1'b0;
        repeat (4) tick();
        chk("halt_sticky", {31'h0, halted}, 32'd1);
        chk("halt_sticky_addr", {20'h0, imem_addr}, {20'h0, addr_h});
        do_redirect(12'h040);
        chk("halt_resume", {31'h0, halted}, 32'd0);
        wait_valid("halt_resume_timeout");
        chk("halt_resume_pc", {20'h0, out_pc}, 32'h040);

        // Asynchronous reset between edges
        repeat (3) tick();
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_valid", {31'h0, out_valid}, 32'd0);
        chk("areset_addr", {20'h0, imem_addr}, {20'h0, RST_PC});
        chk("areset_halted", {31'h0, halted}, 32'd0);
        tick();
        load_stream(RST_PC);
        resetn = 1'b1;
        repeat (3) tick();
        chk("areset_restart_pc", {20'h0, out_pc}, {20'h0, RST_PC});
        chk("areset_restart_valid", {31'h0, out_valid}, 32'd1);

        // Random traffic
        d0          = n_deliv;
        since_redir = 0;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            r         = int'($urandom_range(0, 99));
            halt      = (r >= 4 && r < 6);
            if (r < 4 || since_redir > 40) begin
                do_redirect(12'($urandom));
                since_redir = 0;
            end else begin
                tick();
                since_redir++;
            end
        end
        halt      = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("random_progress", {31'h0, (n_deliv - d0) >= 500}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
